// File: rtl/ieee754_pkg.sv
// Shared types, constants and helpers for the IEEE-754 single-precision accumulator.
package ieee754_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
  localparam logic [9:0]  EXP_BIAS   = 10'd127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_OUT   = 3'd5
  } acc_state_e;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  // Right shift of a {1.f,G,R,S} mantissa; every bit pushed past S is ORed into S.
  function automatic logic [26:0] shift_sticky(input logic [26:0] m, input logic [7:0] sh);
    logic [26:0] mask;
    if (sh >= 8'd27) begin
      shift_sticky = {26'd0, |m};
    end else begin
      mask         = ~(27'h7FF_FFFF << sh);
      shift_sticky = (m >> sh) | {26'd0, |(m & mask)};
    end
  endfunction

endpackage

// File: rtl/ieee754_accumulator_if.sv
// Product-stream input and packet-sum output handshakes of the accumulator.
interface ieee754_accumulator_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [2:0]       out_flags;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_flags, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_flags, out_count
  );
endinterface

// File: rtl/ieee754_lzc.sv
// 27-bit leading-zero counter used to renormalise the adder result.
module ieee754_lzc (
  input  logic [26:0] din,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Highest set bit wins because the scan runs from LSB to MSB.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (din[i]) begin
        count = 5'(26 - i);
      end else begin
        count = count;
      end
    end
  end

  assign all_zero = (din == 27'd0);

endmodule

// File: rtl/ieee754_accumulator.sv
// Multi-cycle fp32 packet accumulator: ALIGN -> ADD -> NORM -> ROUND per term, one sum per packet.
module ieee754_accumulator
  import ieee754_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ieee754_accumulator_if.slave bus
);

  acc_state_e        state_r;
  logic [31:0]       acc_r, term_r, spec_val_r;
  logic [2:0]        flags_r;
  logic [CNT_W-1:0]  count_r;
  logic              last_r, in_ready_r, out_valid_r;
  logic              spec_r, sub_r, sign_r, zero_r, uf_r;
  logic [26:0]       big_mant_r, small_mant_r, mant_r;
  logic [27:0]       sum_r;
  logic signed [9:0] exp_r;

  fp32_t             a_s, b_s;
  logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [26:0]       ma_s, mb_s, big_mant_s, small_mant_s;
  logic [30:0]       mag_a_s, mag_b_s;
  logic              big_sign_s, spec_s;
  logic [7:0]        big_exp_s;
  logic [31:0]       spec_val_s;
  logic [4:0]        lz_s;
  logic              lz_zero_s, norm_zero_s, norm_uf_s, round_up_s;
  logic [26:0]       norm_mant_s;
  logic signed [9:0] norm_exp_s, rnd_exp_s;
  logic [24:0]       rounded_s;
  logic [22:0]       rnd_frac_s;
  logic [31:0]       result_s;
  logic [2:0]        res_flags_s;

  // ALIGN: classify operands (denormals flush to zero) and line up the smaller magnitude.
  always_comb begin
    a_s      = acc_r;
    b_s      = term_r;
    a_zero_s = (a_s.exp == 8'd0);
    b_zero_s = (b_s.exp == 8'd0);
    a_inf_s  = (a_s.exp == 8'hFF) && (a_s.frac == 23'd0);
    b_inf_s  = (b_s.exp == 8'hFF) && (b_s.frac == 23'd0);
    a_nan_s  = (a_s.exp == 8'hFF) && (a_s.frac != 23'd0);
    b_nan_s  = (b_s.exp == 8'hFF) && (b_s.frac != 23'd0);
    if (a_zero_s) begin
      ma_s = 27'd0; mag_a_s = 31'd0;
    end else begin
      ma_s = {1'b1, a_s.frac, 3'b000}; mag_a_s = {a_s.exp, a_s.frac};
    end
    if (b_zero_s) begin
      mb_s = 27'd0; mag_b_s = 31'd0;
    end else begin
      mb_s = {1'b1, b_s.frac, 3'b000}; mag_b_s = {b_s.exp, b_s.frac};
    end
    if (mag_a_s >= mag_b_s) begin
      big_mant_s   = ma_s;
      big_sign_s   = a_s.sign;
      big_exp_s    = a_s.exp;
      small_mant_s = shift_sticky(mb_s, a_s.exp - b_s.exp);
    end else begin
      big_mant_s   = mb_s;
      big_sign_s   = b_s.sign;
      big_exp_s    = b_s.exp;
      small_mant_s = shift_sticky(ma_s, b_s.exp - a_s.exp);
    end
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_s.sign != b_s.sign))) begin
      spec_s = 1'b1; spec_val_s = FP_QNAN;
    end else if (a_inf_s) begin
      spec_s = 1'b1; spec_val_s = acc_r;
    end else if (b_inf_s) begin
      spec_s = 1'b1; spec_val_s = term_r;
    end else if (a_zero_s && b_zero_s) begin
      spec_s = 1'b1; spec_val_s = {a_s.sign & b_s.sign, 31'd0};
    end else begin
      spec_s = 1'b0; spec_val_s = 32'd0;
    end
  end

  ieee754_lzc u_lzc (
    .din      (sum_r[26:0]),
    .count    (lz_s),
    .all_zero (lz_zero_s)
  );

  // NORM: undo an adder carry or shift out leading zeros; exponent <= 0 is underflow.
  always_comb begin
    if (sum_r[27]) begin
      norm_mant_s = {sum_r[27:2], sum_r[1] | sum_r[0]};
      norm_exp_s  = exp_r + 10'sd1;
      norm_zero_s = 1'b0;
    end else begin
      norm_mant_s = sum_r[26:0] << lz_s;
      norm_exp_s  = exp_r - $signed({5'd0, lz_s});
      norm_zero_s = lz_zero_s;
    end
    norm_uf_s = !norm_zero_s && (norm_exp_s <= 10'sd0);
  end

  // ROUND: nearest-even on G/R/S, then map specials, zero, underflow and overflow.
  always_comb begin
    round_up_s  = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    rounded_s   = {1'b0, mant_r[26:3]} + {24'd0, round_up_s};
    res_flags_s = 3'b000;
    if (rounded_s[24]) begin
      rnd_exp_s = exp_r + 10'sd1; rnd_frac_s = rounded_s[23:1];
    end else begin
      rnd_exp_s = exp_r; rnd_frac_s = rounded_s[22:0];
    end
    if (spec_r) begin
      result_s = spec_val_r;
      res_flags_s[FLAG_INVALID] = (spec_val_r == FP_QNAN);
    end else if (zero_r) begin
      result_s = 32'd0;
    end else if (uf_r) begin
      result_s = {sign_r, 31'd0};
      res_flags_s[FLAG_UNDERFLOW] = 1'b1;
    end else if (rnd_exp_s >= 10'sd255) begin
      result_s = sign_r ? FP_NEG_INF : FP_POS_INF;
      res_flags_s[FLAG_OVERFLOW] = 1'b1;
    end else begin
      result_s = {sign_r, rnd_exp_s[7:0], rnd_frac_s};
    end
  end

  // Control FSM and pipeline registers for one term in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;   acc_r <= 32'd0;    term_r <= 32'd0;   spec_val_r <= 32'd0;
      flags_r <= 3'b000;    count_r <= '0;     last_r <= 1'b0;    in_ready_r <= 1'b1;
      out_valid_r <= 1'b0;  spec_r <= 1'b0;    sub_r <= 1'b0;     sign_r <= 1'b0;
      zero_r <= 1'b0;       uf_r <= 1'b0;      big_mant_r <= 27'd0;
      small_mant_r <= 27'd0; mant_r <= 27'd0;  sum_r <= 28'd0;    exp_r <= 10'sd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            term_r     <= bus.in_data;
            last_r     <= bus.in_last;
            count_r    <= (count_r == {CNT_W{1'b1}}) ? count_r : count_r + CNT_W'(1);
            in_ready_r <= 1'b0;
            state_r    <= ST_ALIGN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ALIGN: begin
          big_mant_r   <= big_mant_s;
          small_mant_r <= small_mant_s;
          sign_r       <= big_sign_s;
          sub_r        <= a_s.sign ^ b_s.sign;
          exp_r        <= $signed({2'b00, big_exp_s});
          spec_r       <= spec_s;
          spec_val_r   <= spec_val_s;
          state_r      <= ST_ADD;
        end
        ST_ADD: begin
          sum_r   <= sub_r ? ({1'b0, big_mant_r} - {1'b0, small_mant_r})
                           : ({1'b0, big_mant_r} + {1'b0, small_mant_r});
          state_r <= ST_NORM;
        end
        ST_NORM: begin
          mant_r  <= norm_mant_s;
          exp_r   <= norm_exp_s;
          zero_r  <= norm_zero_s;
          uf_r    <= norm_uf_s;
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          acc_r   <= result_s;
          flags_r <= flags_r | res_flags_s;
          if (last_r) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            acc_r       <= 32'd0;
            flags_r     <= 3'b000;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // in_ready is forced low while reset is held so no word is offered during reset.
  assign bus.in_ready  = in_ready_r & rst_n;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = acc_r;
  assign bus.out_flags = flags_r;
  assign bus.out_count = count_r;

endmodule

// File: tb/tb_ieee754_accumulator.sv
// Directed scoreboard bench for ieee754_accumulator: packets in, expected sums queued and popped on out_valid.
module tb_ieee754_accumulator;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
    logic [15:0] count;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   nvec = 0;
  int   nerr = 0;
  time  t_first;
  time  t_last_hs;

  ieee754_accumulator_if #(.CNT_W(16)) bus ();

  ieee754_accumulator #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic timeout_fail(input string tag);
    nvec++;
    nerr++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic expect_pkt(input logic [31:0] d, input logic [2:0] f, input logic [15:0] c);
    exp_t e;
    e.data = d; e.flags = f; e.count = c;
    sb_q.push_back(e);
  endtask

  // Called and returns on a falling edge; in_data is scrambled after the handshake.
  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("in_ready_wait");
    @(posedge clk);
    t_last_hs = $time;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = $urandom();
  endtask

  // lat < 0 skips the latency check; hold = cycles of out_ready=0 before accepting.
  task automatic collect(input string tag, input int hold, input int lat);
    exp_t        e;
    logic [31:0] held;
    int          n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100 || sb_q.size() == 0) begin
      timeout_fail(tag);
      return;
    end
    if (lat >= 0) chk({tag, "_latency"}, 32'($time - t_first), 32'(lat));
    e = sb_q.pop_front();
    chk({tag, "_data"}, bus.out_data, e.data);
    chk({tag, "_flags"}, {29'd0, bus.out_flags}, {29'd0, e.flags});
    chk({tag, "_count"}, {16'd0, bus.out_count}, {16'd0, e.count});
    held = e.data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_data"}, bus.out_data, held);
      chk({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_acc_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_acc_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    t_first = 0; t_last_hs = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_flags", {29'd0, bus.out_flags}, 32'd0);
    chk("rst_out_count", {16'd0, bus.out_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1.0 + 2.0 back to back; out_valid is first seen mid-cycle 9.5 periods after the first handshake edge
    expect_pkt(32'h4040_0000, 3'b000, 16'd2);
    send(32'h3F80_0000, 1'b0);
    t_first = t_last_hs;
    send(32'h4000_0000, 1'b1);
    collect("sum3", 0, 95);

    expect_pkt(32'h0000_0000, 3'b000, 16'd2);
    send(32'h4184_0000, 1'b0); send(32'hC184_0000, 1'b1);
    collect("cancel", 0, -1);

    expect_pkt(32'h3F80_0000, 3'b000, 16'd2);
    send(32'h3F80_0000, 1'b0); send(32'h3380_0000, 1'b1);
    collect("tie_even", 0, -1);

    expect_pkt(32'h3F80_0001, 3'b000, 16'd2);
    send(32'h3F80_0000, 1'b0); send(32'h3380_0001, 1'b1);
    collect("round_up", 0, -1);

    expect_pkt(32'h7F80_0000, 3'b010, 16'd2);
    send(32'h7F7F_FFFF, 1'b0); send(32'h7F7F_FFFF, 1'b1);
    collect("overflow", 0, -1);

    expect_pkt(32'h7FC0_0000, 3'b100, 16'd2);
    send(32'h7F80_0000, 1'b0); send(32'hFF80_0000, 1'b1);
    collect("inf_minus_inf", 0, -1);

    expect_pkt(32'h0000_0000, 3'b001, 16'd2);
    send(32'h0080_0001, 1'b0); send(32'h8080_0000, 1'b1);
    collect("underflow", 0, -1);

    expect_pkt(32'h0000_0000, 3'b000, 16'd1);
    send(32'h8000_0001, 1'b1);
    collect("denorm_ftz", 0, -1);

    expect_pkt(32'h7FC0_0000, 3'b100, 16'd2);
    send(32'h7F80_0001, 1'b0); send(32'h3F80_0000, 1'b1);
    collect("nan_sticky_bp", 7, -1);

    expect_pkt(32'h4040_0000, 3'b000, 16'd1);
    send(32'h4040_0000, 1'b1);
    collect("fresh_after_nan", 0, -1);

    // Second term is in NORM two falling edges after its handshake returns
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_acc", bus.out_data, 32'd0);
    chk("midrst_count", {16'd0, bus.out_count}, 32'd0);
    @(negedge clk);
    expect_pkt(32'h4000_0000, 3'b000, 16'd1);
    send(32'h4000_0000, 1'b1);
    collect("after_rst", 0, -1);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
